superscaler_processor: RTL and testbench

// 2-way in-order superscalar 32-bit CPU, top level of the design. Fetches an instruction pair per cycle

---
 rtl/superscaler_pkg.sv | 70 +++++++
 rtl/superscaler_alu.sv | 46 ++++
 rtl/superscaler_processor.sv | 144 ++++++++++++++
 tb/tb_superscaler_processor.sv | 138 +++++++++++++
 4 files changed

// File: rtl/superscaler_pkg.sv
// Shared opcodes, instruction field positions and pipeline register types
// for the 2-way in-order superscalar core.
package superscaler_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_MUL  = 6'h02, OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04, OP_XOR  = 6'h05, OP_SLL  = 6'h06, OP_SRL  = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SUBI = 6'h09, OP_ANDI = 6'h0A, OP_ORI  = 6'h0B;
    localparam logic [5:0] OP_XORI = 6'h0C, OP_LW   = 6'h10, OP_SW   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h18, OP_BNE  = 6'h19, OP_BLT  = 6'h1A, OP_BGE  = 6'h1B;
    localparam logic [5:0] OP_J    = 6'h20, OP_JAL  = 6'h21, OP_NOP  = 6'h3F;

    localparam int unsigned OP_HI  = 31, OP_LO  = 26;
    localparam int unsigned RS1_HI = 25, RS1_LO = 21;
    localparam int unsigned RS2_HI = 20, RS2_LO = 16;
    localparam int unsigned RD_HI  = 15, RD_LO  = 11;

    localparam logic [31:0] NOP_WORD = {OP_NOP, 26'd0};

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
    } dest_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins0;
        logic [31:0] ins1;
    } ifid_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        dest_t       dst;
    } idex_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
    } exwb_t;

    function automatic logic is_alu_r(input logic [5:0] op);
        return op <= OP_SRL;
    endfunction

    function automatic logic is_alu_i(input logic [5:0] op);
        return (op >= OP_ADDI) && (op <= OP_XORI);
    endfunction

    function automatic logic is_ctrl(input logic [5:0] op);
        return ((op >= OP_BEQ) && (op <= OP_BGE)) || (op == OP_J) || (op == OP_JAL);
    endfunction

    // rd_i is the [20:16] field (I/LW destination), rd_r the [15:11] field (R destination)
    function automatic dest_t dest_of(input logic [5:0] op, input logic [4:0] rd_i,
                                      input logic [4:0] rd_r);
        dest_t d;
        d = '0;
        if (is_alu_r(op))                      d.rd = rd_r;
        else if (is_alu_i(op) || op == OP_LW)  d.rd = rd_i;
        else if (op == OP_JAL)                 d.rd = 5'd31;
        d.we = (d.rd != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/superscaler_alu.sv
// Per-lane ALU: arithmetic/logic result, LW/SW effective address and
// branch/jump taken decision.
module superscaler_alu
    import superscaler_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [15:0] imm,
    output logic [31:0] result,
    output logic        branch_taken
);

    logic [31:0] sext;
    logic [31:0] zext;

    always_comb begin
        sext         = {{16{imm[15]}}, imm};
        zext         = {16'd0, imm};
        result       = '0;
        branch_taken = 1'b0;
        case (op)
            OP_ADD:         result = a + b;
            OP_SUB:         result = a - b;
            OP_MUL:         result = a * b;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_XOR:         result = a ^ b;
            OP_SLL:         result = a << b[4:0];
            OP_SRL:         result = a >> b[4:0];
            OP_ADDI:        result = a + sext;
            OP_SUBI:        result = a - sext;
            OP_ANDI:        result = a & zext;
            OP_ORI:         result = a | zext;
            OP_XORI:        result = a ^ zext;
            OP_LW, OP_SW:   result = a + sext;
            OP_BEQ:         branch_taken = (a == b);
            OP_BNE:         branch_taken = (a != b);
            OP_BLT:         branch_taken = ($signed(a) <  $signed(b));
            OP_BGE:         branch_taken = ($signed(a) >= $signed(b));
            OP_J, OP_JAL:   branch_taken = 1'b1;
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/superscaler_processor.sv
// 2-way in-order superscalar core: IF -> ID -> EX -> WB, lane 0 general,
// lane 1 ALU-only, unified word memory MEM and register file REG.
module superscaler_processor
    import superscaler_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1028
) (
    input logic clk1,
    input logic reset
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic [31:0] REG [0:31];
    logic [31:0] MEM [0:MEM_DEPTH-1];

    logic [31:0] pc;
    ifid_t       ifid;
    idex_t       idex0, idex1, nxt0, nxt1;
    exwb_t       exwb0, exwb1, ex_res0, ex_res1;
    logic [31:0] alu0, alu1, fetch_pc, redirect_pc;
    logic        taken0, taken1, split, raw, redirect;
    logic [5:0]  op0, op1, ex0_op;
    dest_t       d0, d1;

    function automatic logic [31:0] mem_rd(input logic [31:0] addr, input logic [31:0] dflt);
        return (addr < MEM_DEPTH) ? MEM[addr[AW-1:0]] : dflt;
    endfunction

    // Youngest producer wins: EX over WB, lane 1 over lane 0 within a stage
    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (ex_res1.we && ex_res1.rd == r) return ex_res1.val;
        if (ex_res0.we && ex_res0.rd == r) return ex_res0.val;
        if (exwb1.we && exwb1.rd == r)     return exwb1.val;
        if (exwb0.we && exwb0.rd == r)     return exwb0.val;
        return REG[r];
    endfunction

    function automatic logic [31:0] target_of(input idex_t s);
        if (s.ins[OP_HI:OP_LO] == OP_J || s.ins[OP_HI:OP_LO] == OP_JAL)
            return {6'd0, s.ins[25:0]};
        return s.pc + 32'd1 + {{16{s.ins[15]}}, s.ins[15:0]};
    endfunction

    superscaler_alu u_alu0 (
        .op(idex0.ins[OP_HI:OP_LO]), .a(idex0.a), .b(idex0.b), .imm(idex0.ins[15:0]),
        .result(alu0), .branch_taken(taken0)
    );

    superscaler_alu u_alu1 (
        .op(idex1.ins[OP_HI:OP_LO]), .a(idex1.a), .b(idex1.b), .imm(idex1.ins[15:0]),
        .result(alu1), .branch_taken(taken1)
    );

    always_comb begin
        ex0_op      = idex0.ins[OP_HI:OP_LO];
        ex_res0.we  = idex0.valid && idex0.dst.we;
        ex_res0.rd  = idex0.dst.rd;
        ex_res0.val = alu0;
        if (ex0_op == OP_LW)       ex_res0.val = mem_rd(alu0, '0);
        else if (ex0_op == OP_JAL) ex_res0.val = idex0.pc + 32'd1;
        ex_res1.we  = idex1.valid && idex1.dst.we;
        ex_res1.rd  = idex1.dst.rd;
        ex_res1.val = alu1;
    end

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (idex0.valid && taken0) begin
            redirect    = 1'b1;
            redirect_pc = target_of(idex0);
        end else if (idex1.valid && taken1) begin
            redirect    = 1'b1;
            redirect_pc = target_of(idex1);
        end
    end

    always_comb begin
        op0   = ifid.ins0[OP_HI:OP_LO];
        op1   = ifid.ins1[OP_HI:OP_LO];
        d0    = dest_of(op0, ifid.ins0[RS2_HI:RS2_LO], ifid.ins0[RD_HI:RD_LO]);
        d1    = dest_of(op1, ifid.ins1[RS2_HI:RS2_LO], ifid.ins1[RD_HI:RD_LO]);
        raw   = d0.we && (((is_alu_r(op1) || is_alu_i(op1)) && ifid.ins1[RS1_HI:RS1_LO] == d0.rd)
                          || (is_alu_r(op1) && ifid.ins1[RS2_HI:RS2_LO] == d0.rd));
        split = raw || op1 == OP_LW || op1 == OP_SW || is_ctrl(op1) || is_ctrl(op0);

        nxt0.valid = ifid.valid;
        nxt0.pc    = ifid.pc;
        nxt0.ins   = ifid.ins0;
        nxt0.a     = fwd(ifid.ins0[RS1_HI:RS1_LO]);
        nxt0.b     = fwd(ifid.ins0[RS2_HI:RS2_LO]);
        nxt0.dst   = d0;
        nxt1.valid = ifid.valid && !split;
        nxt1.pc    = ifid.pc + 32'd1;
        nxt1.ins   = ifid.ins1;
        nxt1.a     = fwd(ifid.ins1[RS1_HI:RS1_LO]);
        nxt1.b     = fwd(ifid.ins1[RS2_HI:RS2_LO]);
        nxt1.dst   = d1;
    end

    // On a split the held lane-1 instruction is refetched as the next pair's lane 0
    always_comb fetch_pc = (ifid.valid && split) ? ifid.pc + 32'd1 : pc;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            ifid  <= '0;
            idex0 <= '0;
            idex1 <= '0;
            exwb0 <= '0;
            exwb1 <= '0;
        end else begin
            exwb0 <= ex_res0;
            exwb1 <= ex_res1;
            if (redirect) begin
                pc    <= redirect_pc;
                ifid  <= '0;
                idex0 <= '0;
                idex1 <= '0;
            end else begin
                pc         <= fetch_pc + 32'd2;
                ifid.valid <= 1'b1;
                ifid.pc    <= fetch_pc;
                ifid.ins0  <= mem_rd(fetch_pc, NOP_WORD);
                ifid.ins1  <= mem_rd(fetch_pc + 32'd1, NOP_WORD);
                idex0      <= nxt0;
                idex1      <= nxt1;
            end
        end
    end

    // Reset holds exwb/idex invalid, so neither array is written while reset is high
    always_ff @(posedge clk1) begin
        if (exwb0.we) REG[exwb0.rd] <= exwb0.val;
        if (exwb1.we) REG[exwb1.rd] <= exwb1.val;
    end

    always_ff @(posedge clk1) begin
        if (idex0.valid && ex0_op == OP_SW && alu0 < MEM_DEPTH)
            MEM[alu0[AW-1:0]] <= idex0.b;
    end

endmodule

// File: tb/tb_superscaler_processor.sv
// Directed bench for superscaler_processor: intra/cross-pair hazards, ALU ops,
// memory, branches/jumps and mid-run reset, with hand-computed results.
module tb_superscaler_processor;

    localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, MUL = 6'h02, SLL = 6'h06, SRL = 6'h07;
    localparam logic [5:0] ADDI = 6'h08, ORI = 6'h0B, LW = 6'h10, SW = 6'h11;
    localparam logic [5:0] BEQ = 6'h18, BNE = 6'h19, BLT = 6'h1A, J = 6'h20, JAL = 6'h21;
    localparam logic [31:0] NOPW = {6'h3F, 26'd0};

    logic clk1 = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] exp_reg [0:31];
    logic [31:0] snap_r1, snap_m;

    superscaler_processor #(.MEM_DEPTH(1028)) dut (
        .clk1 (clk1),
        .reset(reset)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [4:0] rd);
        return {op, rs1, rs2, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs1, rd, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic enter_reset();
        @(negedge clk1);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) dut.REG[i] = i;
        for (int i = 0; i < 1028; i++) dut.MEM[i] = NOPW;
    endtask

    task automatic release_reset();
        #30;
        @(negedge clk1);
        check_eq("pc_in_reset", dut.pc, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Phase 1: intra-pair RAW split and cross-pair EX/WB forwarding
        enter_reset();
        dut.MEM[0] = enc_r(ADD, 1, 2, 14);
        dut.MEM[1] = enc_r(ADD, 2, 14, 15);
        dut.MEM[3] = enc_r(ADD, 1, 15, 17);
        dut.MEM[4] = enc_r(ADD, 1, 14, 18);
        release_reset();
        repeat (20) @(negedge clk1);
        check_eq("p1_r14", dut.REG[14], 32'd3);
        check_eq("p1_r15", dut.REG[15], 32'd5);
        check_eq("p1_r17", dut.REG[17], 32'd6);
        check_eq("p1_r18", dut.REG[18], 32'd4);

        // Phase 2: ordering, SUB, memory, branches, jumps, immediates, WAW, R0
        enter_reset();
        for (int k = 0; k < 8; k++) dut.MEM[8 + k] = enc_r(ADD, 5, 5'(2 + k), 5'(14 + k));
        for (int k = 0; k < 6; k++) dut.MEM[20 + k] = enc_r(SUB, 30, 5'(4 + k), 5'(16 + k));
        dut.MEM[30] = enc_i(SW, 0, 3, 16'd100);
        dut.MEM[31] = enc_i(LW, 0, 22, 16'd100);
        dut.MEM[32] = enc_i(BEQ, 0, 0, 16'd2);
        dut.MEM[33] = enc_r(ADD, 1, 1, 23);
        dut.MEM[34] = enc_r(ADD, 1, 1, 24);
        dut.MEM[35] = enc_r(MUL, 3, 4, 25);
        dut.MEM[36] = enc_j(JAL, 26'd40);
        dut.MEM[37] = enc_r(ADD, 1, 1, 26);
        dut.MEM[40] = enc_i(ADDI, 0, 27, 16'hFFFB);
        dut.MEM[41] = enc_r(SLL, 2, 3, 28);
        dut.MEM[42] = enc_r(SRL, 30, 1, 29);
        dut.MEM[44] = enc_r(ADD, 1, 1, 10);
        dut.MEM[45] = enc_r(ADD, 2, 2, 10);
        dut.MEM[46] = enc_i(BNE, 0, 0, 16'd5);
        dut.MEM[47] = enc_i(ADDI, 0, 11, 16'h8000);
        dut.MEM[48] = enc_i(ORI, 0, 12, 16'h8000);
        dut.MEM[49] = enc_i(BLT, 27, 1, 16'd1);
        dut.MEM[50] = enc_r(ADD, 1, 1, 13);
        dut.MEM[51] = enc_r(ADD, 1, 1, 0);
        release_reset();
        repeat (100) @(negedge clk1);
        for (int i = 0; i < 32; i++) exp_reg[i] = i;
        exp_reg[10] = 32'd4;
        exp_reg[11] = 32'hFFFF_8000;
        exp_reg[12] = 32'h0000_8000;
        exp_reg[14] = 32'd7;
        exp_reg[15] = 32'd8;
        for (int k = 0; k < 6; k++) exp_reg[16 + k] = 32'(26 - k);
        exp_reg[22] = 32'd3;
        exp_reg[25] = 32'd12;
        exp_reg[27] = 32'hFFFF_FFFB;
        exp_reg[28] = 32'd16;
        exp_reg[29] = 32'd15;
        exp_reg[31] = 32'd37;
        for (int i = 0; i < 32; i++) check_eq($sformatf("p2_r%0d", i), dut.REG[i], exp_reg[i]);
        check_eq("p2_mem100", dut.MEM[100], 32'd3);

        // Phase 3: reset asserted while a store/increment loop is running
        enter_reset();
        dut.MEM[0] = enc_i(ADDI, 1, 1, 16'd1);
        dut.MEM[1] = enc_i(SW, 0, 1, 16'd200);
        dut.MEM[2] = enc_j(J, 26'd0);
        release_reset();
        repeat (30) @(negedge clk1);
        #2;
        reset = 1'b1;
        #1;
        snap_r1 = dut.REG[1];
        snap_m  = dut.MEM[200];
        check_eq("p3_loop_ran", 32'(snap_r1 > 32'd3), 32'd1);
        check_eq("p3_pc_async", dut.pc, 32'd0);
        repeat (6) @(negedge clk1);
        check_eq("p3_r1_held", dut.REG[1], snap_r1);
        check_eq("p3_mem_held", dut.MEM[200], snap_m);
        check_eq("p3_pc_held", dut.pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
